// File: rtl/wave_if.sv
// wave_if: signal bundle between the wave sequencer and the rest of the game.
// Ports (by modport):
//   slave  - the sequencer: takes fsync, start, alien_hit, player_hit,
//            aliens_remaining, alien_reached_paddle; drives speed, group_rst,
//            state, playing, score, lives, level.
//   master - the opposite view, for whatever drives the inputs and watches the outputs.
// Parameter AW sets the width of aliens_remaining.
interface wave_if #(
    parameter int AW = 6
);
    logic          fsync;
    logic          start;
    logic          alien_hit;
    logic          player_hit;
    logic [AW-1:0] aliens_remaining;
    logic          alien_reached_paddle;
    logic [7:0]    speed;
    logic          group_rst;
    logic [1:0]    state;
    logic          playing;
    logic [15:0]   score;
    logic [1:0]    lives;
    logic [3:0]    level;

    modport master (
        output fsync, start, alien_hit, player_hit, aliens_remaining, alien_reached_paddle,
        input  speed, group_rst, state, playing, score, lives, level
    );

    modport slave (
        input  fsync, start, alien_hit, player_hit, aliens_remaining, alien_reached_paddle,
        output speed, group_rst, state, playing, score, lives, level
    );
endinterface

// File: rtl/wave_controller.sv
// wave_controller: frame-rate game sequencer sitting after alien_group.
// It keeps the BCD score, the lives and the level. It drives the alien speed
// and holds alien_group in reset whenever the game is not in PLAY.
// Ports:
//   pixel_clk - sole clock
//   rst       - asynchronous, active-high reset
//   bus       - wave_if.slave. Inputs: fsync, start, alien_hit, player_hit,
//               aliens_remaining, alien_reached_paddle. Outputs: speed,
//               group_rst, state, playing, score, lives, level. All outputs
//               are registered.
// Optional feature: define WAVE_BONUS_EN to add 100 points on each wave clear.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ATTRACT  | idle after reset, waiting for a start edge
// PLAY     | wave in progress; hits score, game decisions taken on fsync
// PAUSE    | frame countdown after a wave clear or a lost life
// OVER     | game over; results held until the next start edge
module wave_controller #(
    parameter int START_LIVES  = 3,
    parameter int BASE_SPEED   = 1,
    parameter int SPEED_STEP   = 1,
    parameter int MAX_SPEED    = 8,
    parameter int CLEAR_FRAMES = 120,
    parameter int DEATH_FRAMES = 60,
    parameter int NUM_ROWS     = 5,
    parameter int NUM_COLS     = 11,
    parameter int AW           = $clog2(NUM_ROWS*NUM_COLS+1)
) (
    input logic  pixel_clk,
    input logic  rst,
    wave_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_PLAY    = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [AW-1:0] NO_ALIENS = '0;

    state_t      state_q, next_state;
    logic        start_q;
    logic        hit_q;
    logic        ph_pend;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  speed_q;
    logic        group_rst_q;
    logic        playing_q;
    logic        new_game;
    logic        clear_evt;
    logic        start_edge;
    logic        hit_edge;

    assign start_edge = bus.fsync & bus.start & ~start_q;
    assign hit_edge   = bus.alien_hit & ~hit_q;

    // speed = min(BASE + (level-1)*STEP, MAX) computed in 12 bits, then clipped to 8 bits
    function automatic logic [7:0] calc_speed(input logic [3:0] lvl);
        logic [11:0] s;
        s = 12'(BASE_SPEED) + (12'(lvl) - 12'd1) * 12'(SPEED_STEP);
        if (s > 12'(MAX_SPEED)) s = 12'(MAX_SPEED);
        return (s > 12'd255) ? 8'hFF : s[7:0];
    endfunction

    // Adds 10^pos to a 4-digit BCD value. A carry out of the thousands digit
    // saturates at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v, input int pos);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (d >= pos && carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) r = 16'h9999;
        return r;
    endfunction

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) state_q <= ST_ATTRACT;
        else     state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        new_game   = 1'b0;
        clear_evt  = 1'b0;
        if (bus.fsync) begin
            case (state_q)
                ST_ATTRACT, ST_OVER: begin
                    if (start_edge) begin
                        next_state = ST_PLAY;
                        new_game   = 1'b1;
                        lives_d    = 2'(START_LIVES);
                        level_d    = 4'd1;
                    end
                end
                ST_PLAY: begin
                    // A wave clear outranks any pending hit.
                    if (bus.aliens_remaining == NO_ALIENS) begin
                        next_state = ST_PAUSE;
                        clear_evt  = 1'b1;
                        level_d    = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                        cnt_d      = 8'(CLEAR_FRAMES);
                    end else if (bus.alien_reached_paddle || ph_pend || bus.player_hit) begin
                        if (lives_q == 2'd1) begin
                            next_state = ST_OVER;
                            lives_d    = 2'd0;
                        end else begin
                            next_state = ST_PAUSE;
                            lives_d    = lives_q - 2'd1;
                            cnt_d      = 8'(DEATH_FRAMES);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (cnt_q == 8'd1) next_state = ST_PLAY;
                    cnt_d = cnt_q - 8'd1;
                end
                default: next_state = ST_ATTRACT;
            endcase
        end
    end

    always_comb begin
        score_d = score_q;
        if (new_game) begin
            score_d = '0;
        end else begin
            if (hit_edge && state_q == ST_PLAY) score_d = bcd_inc(score_d, 0);
`ifdef WAVE_BONUS_EN
            if (clear_evt) score_d = bcd_inc(score_d, 2);
`else
`endif
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b1;
            hit_q       <= 1'b0;
            ph_pend     <= 1'b0;
            cnt_q       <= '0;
            lives_q     <= '0;
            level_q     <= '0;
            score_q     <= '0;
            speed_q     <= 8'(BASE_SPEED);
            group_rst_q <= 1'b1;
            playing_q   <= 1'b0;
        end else begin
            if (bus.fsync) start_q <= bus.start;
            hit_q   <= bus.alien_hit;
            cnt_q   <= cnt_d;
            lives_q <= lives_d;
            level_q <= level_d;
            score_q <= score_d;
            if (new_game || clear_evt) speed_q <= calc_speed(level_d);
            // A hit that lands on the evaluating fsync is consumed by that
            // evaluation rather than carried into the next frame.
            if (state_q != ST_PLAY || bus.fsync) ph_pend <= 1'b0;
            else if (bus.player_hit)             ph_pend <= 1'b1;
            group_rst_q <= (next_state != ST_PLAY);
            playing_q   <= (next_state == ST_PLAY);
        end
    end

    assign bus.state     = state_q;
    assign bus.playing   = playing_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.level     = level_q;
    assign bus.speed     = speed_q;
    assign bus.group_rst = group_rst_q;

endmodule
